// File: rtl/booth_pp_accum.sv
// Radix-4 Booth partial-product accumulator: sums four weighted 9-bit terms into a 16-bit signed product.
// Optional BOOTH_ACCUM_DUAL_EN: accumulate two terms per cycle (latency 2 instead of 4).
//
// state | meaning
// IDLE  | waiting for an operand set, in_ready=1
// ACCUM | adding latched terms into acc, one (or two) per cycle
// DONE  | product valid, held until out_ready
module booth_pp_accum #(
    parameter int PP_W  = 9,
    parameter int NPP   = 4,
    parameter int OUT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [PP_W-1:0]  pp0,
    input  logic [PP_W-1:0]  pp1,
    input  logic [PP_W-1:0]  pp2,
    input  logic [PP_W-1:0]  pp3,
    input  logic [NPP-1:0]   n,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] product,
    output logic             busy
);

    localparam int CNT_W = $clog2(NPP);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ACCUM = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    logic [1:0]                 state;
    logic [OUT_W-1:0]           acc;
    logic [CNT_W-1:0]           cnt;
    logic [NPP-1:0][PP_W-1:0]   pp_q;
    logic [NPP-1:0]             n_q;

    // Sign-extended term plus its negate correction, weighted by 4^idx.
    function automatic logic [OUT_W-1:0] term(input logic [CNT_W-1:0] idx);
        logic [OUT_W-1:0] t;
        t = {{(OUT_W-PP_W){pp_q[idx][PP_W-1]}}, pp_q[idx]} + OUT_W'(n_q[idx]);
        return t << {idx, 1'b0};
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            acc   <= '0;
            cnt   <= '0;
            pp_q  <= '0;
            n_q   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        pp_q  <= {pp3, pp2, pp1, pp0};
                        n_q   <= n;
                        acc   <= '0;
                        cnt   <= '0;
                        state <= ACCUM;
                    end
                end
                ACCUM: begin
`ifdef BOOTH_ACCUM_DUAL_EN
                    acc <= acc + term(cnt) + term(cnt + CNT_W'(1));
                    if (cnt == CNT_W'(NPP-2)) begin
                        state <= DONE;
                    end else begin
                        cnt <= cnt + CNT_W'(2);
                    end
`else
                    acc <= acc + term(cnt);
                    if (cnt == CNT_W'(NPP-1)) begin
                        state <= DONE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
`endif
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign product   = acc;

endmodule

// File: tb/tb_booth_pp_accum.sv
// Table-driven bench for booth_pp_accum: product values, latency, backpressure hold and mid-ACCUM reset.
module tb_booth_pp_accum;

`ifdef BOOTH_ACCUM_DUAL_EN
    localparam int LAT        = 2;
    localparam int ABORT_WAIT = 1;
`else
    localparam int LAT        = 4;
    localparam int ABORT_WAIT = 2;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [8:0]  pp0, pp1, pp2, pp3;
    logic [3:0]  n;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] product;
    logic        busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    booth_pp_accum dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .pp0       (pp0),
        .pp1       (pp1),
        .pp2       (pp2),
        .pp3       (pp3),
        .n         (n),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .product   (product),
        .busy      (busy)
    );

    typedef struct {
        string       name;
        logic [8:0]  pp0, pp1, pp2, pp3;
        logic [3:0]  n;
        logic [15:0] exp;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Handshake, scramble inputs while busy, measure latency, check result, then hold and release.
    task automatic do_op(input vec_t v, input int hold);
        int cyc;
        @(negedge clk);
        check({v.name, "_in_ready"}, in_ready, 1);
        in_valid = 1'b1;
        pp0 = v.pp0; pp1 = v.pp1; pp2 = v.pp2; pp3 = v.pp3; n = v.n;
        @(posedge clk);
        @(negedge clk);
        check({v.name, "_busy"}, {busy, in_ready}, 2'b10);
        cyc = 0;
        while (!out_valid && cyc < 20) begin
            pp0 = 9'($urandom); pp1 = 9'($urandom); pp2 = 9'($urandom); pp3 = 9'($urandom);
            n = 4'($urandom);
            @(negedge clk);
            cyc++;
        end
        check({v.name, "_latency"}, cyc, LAT);
        check({v.name, "_product"}, product, v.exp);
        in_valid = 1'b0;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check({v.name, "_hold"}, {out_valid, in_ready, product}, {1'b1, 1'b0, v.exp});
        end
        out_ready = 1'b1;
        @(negedge clk);
        check({v.name, "_release"}, {out_valid, in_ready, busy}, 3'b010);
        out_ready = 1'b0;
    endtask

    initial begin
        vecs[0] = '{"zero",      9'h000, 9'h000, 9'h000, 9'h000, 4'b0000, 16'h0000};
        vecs[1] = '{"pp1_one",   9'h000, 9'h001, 9'h000, 9'h000, 4'b0000, 16'h0004};
        vecs[2] = '{"neg_zero",  9'h1FF, 9'h000, 9'h000, 9'h000, 4'b0001, 16'h0000};
        vecs[3] = '{"m3x5",      9'h003, 9'h003, 9'h000, 9'h000, 4'b0000, 16'h000F};
        vecs[4] = '{"mn128xn128",9'h000, 9'h000, 9'h000, 9'h0FF, 4'b1000, 16'h4000};
        vecs[5] = '{"mn128x127", 9'h07F, 9'h1FF, 9'h1FF, 9'h100, 4'b0111, 16'hC080};
        vecs[6] = '{"m127x127",  9'h180, 9'h1FF, 9'h1FF, 9'h0FE, 4'b0111, 16'h3F01};
        vecs[7] = '{"pp3_min",   9'h000, 9'h000, 9'h000, 9'h100, 4'b0000, 16'hC000};
        vecs[8] = '{"pp2_corr",  9'h000, 9'h000, 9'h0FF, 9'h000, 4'b0100, 16'h1000};
        vecs[9] = '{"pp0_neg",   9'h100, 9'h000, 9'h000, 9'h000, 4'b0000, 16'hFF00};

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        pp0 = '0; pp1 = '0; pp2 = '0; pp3 = '0; n = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_state", {out_valid, in_ready, busy, product}, {3'b010, 16'h0000});
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            do_op(vecs[i], 0);
        end

        do_op(vecs[6], 10);

        // Abort 127*127 mid-ACCUM (cnt=2): partial sum must vanish.
        @(negedge clk);
        in_valid = 1'b1;
        pp0 = vecs[6].pp0; pp1 = vecs[6].pp1; pp2 = vecs[6].pp2; pp3 = vecs[6].pp3; n = vecs[6].n;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (ABORT_WAIT) @(negedge clk);
        check("abort_in_accum", {out_valid, busy}, 2'b01);
        rst_n = 1'b0;
        @(negedge clk);
        check("abort_reset", {out_valid, in_ready, busy, product}, {3'b010, 16'h0000});
        rst_n = 1'b1;
        @(negedge clk);
        check("abort_idle", {out_valid, in_ready, busy, product}, {3'b010, 16'h0000});
        do_op(vecs[3], 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
